// File: rtl/seq_trojan_mc.sv
// Trigger-armed, windowed payload injector sitting on a bank of stochastic bit channels.
// Define SEQ_TROJAN_MC_STATS_EN to build the per-channel flip counters.
module seq_trojan_mc #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TRIG_RUN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       bit_in,
  input  logic                    trigger,
  input  logic [NUM_CH-1:0]       T,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_start,
  input  logic [CNT_W-1:0]        cfg_len,
  input  logic [CNT_W-1:0]        cfg_every,
  input  logic [2:0]              cfg_mode,
  input  logic [NUM_CH-1:0]       cfg_mask,
  input  logic                    cfg_rearm,
  output logic [NUM_CH-1:0]       bit_out,
  output logic                    active,
  output logic                    hit_pulse,
  output logic [2:0]              state,
  output logic [CNT_W-1:0]        hit_count,
  output logic [NUM_CH*CNT_W-1:0] flip_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TRIG_RUN - 1);

  logic [2:0]        r_state, w_state_d;
  logic [CNT_W-1:0]  r_run, w_run_d;
  logic [CNT_W-1:0]  r_dly, w_dly_d;
  logic [CNT_W-1:0]  r_win, w_win_d;
  logic [CNT_W-1:0]  r_per, w_per_d;
  logic [CNT_W-1:0]  r_hit;
  logic [CNT_W-1:0]  r_start, r_len, r_every;
  logic [2:0]        r_mode;
  logic [NUM_CH-1:0] r_mask;
  logic              r_rearm;

  logic              w_cfg_load;
  logic              w_applied;
  logic [CNT_W-1:0]  w_len_last, w_every_last;
  logic [NUM_CH-1:0] w_payload, w_hit_mask;

  // Zero-length window / period behave as length one.
  assign w_len_last   = (r_len == '0) ? '0 : r_len - ONE;
  assign w_every_last = (r_every == '0) ? '0 : r_every - ONE;

  assign cfg_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign active    = (r_state == ST_ACTIVE);
  assign hit_pulse = active && (r_per == '0);
  assign w_applied = hit_pulse && trigger;
  assign state     = r_state;
  assign hit_count = r_hit;

  always_comb begin
    w_state_d  = r_state;
    w_run_d    = r_run;
    w_dly_d    = r_dly;
    w_win_d    = r_win;
    w_per_d    = r_per;
    w_cfg_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (cfg_valid) begin
          w_cfg_load = 1'b1;
          w_run_d    = '0;
          w_state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!trigger) begin
          w_run_d = '0;
        end else if (r_run == RUN_LAST) begin
          w_run_d   = '0;
          w_dly_d   = '0;
          w_state_d = ST_WAIT;
        end else begin
          w_run_d = r_run + ONE;
        end
      end
      ST_WAIT: begin
        // Compare instead of count-down so cfg_start=all-ones gives 2^CNT_W cycles.
        if (r_dly == r_start) begin
          w_win_d   = '0;
          w_per_d   = '0;
          w_state_d = ST_ACTIVE;
        end else begin
          w_dly_d = r_dly + ONE;
        end
      end
      ST_ACTIVE: begin
        w_per_d = (r_per == w_every_last) ? '0 : r_per + ONE;
        if (r_win == w_len_last) begin
          w_run_d   = '0;
          w_state_d = r_rearm ? ST_ARM : ST_DONE;
        end else begin
          w_win_d = r_win + ONE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
      r_dly   <= '0;
      r_win   <= '0;
      r_per   <= '0;
      r_hit   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_every <= '0;
      r_mode  <= '0;
      r_mask  <= '0;
      r_rearm <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_run   <= w_run_d;
      r_dly   <= w_dly_d;
      r_win   <= w_win_d;
      r_per   <= w_per_d;
      if (w_cfg_load) begin
        r_hit   <= '0;
        r_start <= cfg_start;
        r_len   <= cfg_len;
        r_every <= cfg_every;
        r_mode  <= cfg_mode;
        r_mask  <= cfg_mask;
        r_rearm <= cfg_rearm;
      end else if (w_applied && (r_hit != '1)) begin
        r_hit <= r_hit + ONE;
      end
    end
  end

  always_comb begin
    case (r_mode)
      3'd0:    w_payload = ~bit_in;
      3'd1:    w_payload = '1;
      3'd2:    w_payload = '0;
      3'd3:    w_payload = bit_in ^ T;
      3'd4:    w_payload = T;
      default: w_payload = bit_in;
    endcase
    w_hit_mask = {NUM_CH{w_applied}} & r_mask;
    bit_out    = (bit_in & ~w_hit_mask) | (w_payload & w_hit_mask);
  end

`ifdef SEQ_TROJAN_MC_STATS_EN
  logic [CNT_W-1:0] r_flip [NUM_CH];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_flip
    always_ff @(posedge clk) begin
      if (rst || w_cfg_load) begin
        r_flip[c] <= '0;
      end else if ((bit_out[c] != bit_in[c]) && (r_flip[c] != '1)) begin
        r_flip[c] <= r_flip[c] + ONE;
      end
    end
    assign flip_count[c*CNT_W +: CNT_W] = r_flip[c];
  end
`else
  assign flip_count = '0;
`endif

endmodule

// File: doc/seq_trojan_mc.md
SEQ_TROJAN_MC -- requirements
Module: seq_trojan_mc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_CH, default 4: number of stochastic bit channels.
REQ-003 Parameter CNT_W, default 16: width of all cycle and event counters.
REQ-004 Parameter TRIG_RUN, default 4: number of consecutive trigger-high cycles needed to arm (minimum 1).
REQ-005 clk  in  1  clock; every register updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 bit_in  in  NUM_CH  clean stochastic bits, one per channel.
REQ-008 trigger  in  1  external trigger; also gates payload application.
REQ-009 T  in  NUM_CH  per-channel payload value.
REQ-010 cfg_valid  in  1; cfg_ready  out  1  configuration handshake.
REQ-011 cfg_start, cfg_len, cfg_every  in  CNT_W each  wait delay, window length, hit period.
REQ-012 cfg_mode  in  3; cfg_mask  in  NUM_CH; cfg_rearm  in  1  payload mode, channel enable mask, auto-rearm.
REQ-013 bit_out  out  NUM_CH  channel outputs after the trojan.
REQ-014 active  out  1; hit_pulse  out  1; state  out  3  observability signals.
REQ-015 hit_count  out  CNT_W; flip_count  out  NUM_CH*CNT_W  event counters; channel c occupies bits [c*CNT_W +: CNT_W].

Function
REQ-016 States and encodings: IDLE=0, ARM=1, WAIT=2, ACTIVE=3, DONE=4; state SHALL be a registered output.
REQ-017 cfg_ready SHALL be 1 only in IDLE or DONE; a cycle with cfg_valid&&cfg_ready latches every cfg_* input, clears hit_count and flip_count, clears the run counter, and moves to ARM; cfg_valid is ignored in all other states.
REQ-018 ARM: run counter increments when trigger=1 and clears when trigger=0; the TRIG_RUN-th consecutive high cycle moves to WAIT.
REQ-019 WAIT SHALL last exactly cfg_start+1 cycles, then move to ACTIVE.
REQ-020 ACTIVE SHALL last exactly max(cfg_len,1) cycles; on its last cycle the next state is ARM (run counter cleared) if cfg_rearm=1, otherwise DONE.
REQ-021 active=1 exactly when state=ACTIVE.
REQ-022 The period counter resets to 0 on ACTIVE entry and wraps after max(cfg_every,1)-1; hit_pulse = active && (period counter == 0).
REQ-023 Applied hit = hit_pulse && trigger; bit_out[c] takes the payload only on an applied hit with cfg_mask[c]=1; otherwise bit_out[c]=bit_in[c].
REQ-024 Payload by cfg_mode: 0 ~bit_in; 1 constant 1; 2 constant 0; 3 bit_in^T; 4 T; 5-7 pass-through.
REQ-025 bit_out SHALL be combinational from bit_in/T with zero cycle latency; the gating comes only from registered state.
REQ-026 hit_count increments on each applied hit and saturates at all-ones.
REQ-027 Counter widths: all counters are CNT_W bits and SHALL NOT wrap unintentionally; cfg_start=all-ones yields 2^CNT_W WAIT cycles.

Reset
REQ-028 On a rst=1 edge, state SHALL become IDLE and the run, delay, window, period, hit_count and flip_count counters SHALL become 0; latched config is cleared to 0.
REQ-029 After reset: active=0, hit_pulse=0, cfg_ready=1, bit_out=bit_in.
REQ-030 Reset asserted mid-operation (any state) SHALL take effect at the next edge with no further payload applied from that cycle's edge on.
REQ-031 rst SHALL have priority over a simultaneous cfg_valid.

Configuration
REQ-032 Macro SEQ_TROJAN_MC_STATS_EN defined: flip_count[c] increments (saturating) on every cycle where bit_out[c] != bit_in[c].
REQ-033 Macro SEQ_TROJAN_MC_STATS_EN undefined: no flip counters are built; flip_count is tied to 0 and the port is still present.

Verification (NUM_CH=4, TRIG_RUN=4, CNT_W=16)
REQ-034 Reset with bit_in=4'b1010 -> bit_out=4'b1010, state=0, cfg_ready=1, hit_count=0.
REQ-035 Configure start=2, len=8, every=1, mode=0, mask=4'b0001, trigger=1 held -> ARM 4 cycles, WAIT 3 cycles, then 8 cycles with bit_out[0]=~bit_in[0] and bits 3:1 passed through, then hit_count=8 and state=DONE.
REQ-036 In ARM, trigger sequence 1,1,1,0,1,1,1,1 -> WAIT is entered only after the 8th cycle.
REQ-037 Configure len=7, every=3, mode=3, T=4'b1111, mask=4'b1111, trigger low on ACTIVE cycle 3 -> hit_pulse on ACTIVE cycles 0,3,6, payload inverts all channels on cycles 0 and 6 only, hit_count=2.
REQ-038 Configure rearm=1, len=4 -> after ACTIVE the state returns to ARM; rst on ACTIVE cycle 2 -> next cycle state=IDLE, bit_out=bit_in, all counters 0.
REQ-039 With SEQ_TROJAN_MC_STATS_EN defined, mode=1, bit_in=0, mask=4'b0011, len=5 -> flip_count ch0=ch1=5 and ch2=ch3=0; with the macro undefined -> flip_count=0.
